decode_stage: RTL and testbench

- ID stage of the 5-stage ARM pipeline, directly downstream of fetch.
- Takes {valid, inst, pc} from fetch and splits the ARM instruction into register addresses, immediates and control flags.
- Results go into an ID/EX pipeline register that feeds execute.
- Detects load-use hazards against its own registered output, inserts a bubble, and raises stall_o so fetch holds its PC.

---
 rtl/arm_pkg.sv | 68 ++++++
 rtl/hazard_detect.sv | 61 ++++++
 rtl/decode_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM encoding definitions for the decode stage and its helpers.
//   - instruction class encodings taken from inst[27:26]
//   - data-processing opcode values from inst[24:21]
//   - architectural register indices for LR and PC
//   - id_ex_t: the ID/EX pipeline register contents (PC-width fields excluded)
package arm_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_UND = 2'b11
  } inst_class_e;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } dp_op_e;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic        vld;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic [11:0] imm12;
    logic        set_flags;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        up;
    logic        pre;
    logic        branch;
    logic        link;
    logic [23:0] offset;
    logic        writes_pc;
  } id_ex_t;

  // Compare-class ops update flags only; they never write rd.
  function automatic logic is_compare_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // MOV/MVN take only operand2; rn is not read.
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Compares the source registers of the instruction arriving from fetch with
// the destination of a load currently held in the ID/EX register.
//   vld          : fetch instruction is real
//   cls/opc      : inst[27:26] / inst[24:21]
//   i_bit/l_bit  : inst[25] / inst[20]
//   rn/rd/rm     : register fields of the fetch instruction
//   ex_vld/ex_mem_read/ex_rd : state of the ID/EX entry
//   hazard       : dependent instruction must wait one cycle
module hazard_detect
  import arm_pkg::*;
(
  input  logic       vld,
  input  logic [1:0] cls,
  input  logic [3:0] opc,
  input  logic       i_bit,
  input  logic       l_bit,
  input  logic [3:0] rn,
  input  logic [3:0] rd,
  input  logic [3:0] rm,
  input  logic       ex_vld,
  input  logic       ex_mem_read,
  input  logic [3:0] ex_rd,
  output logic       hazard
);

  logic use_rn;
  logic use_rm;
  logic use_rd;
  logic match;

  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rd = 1'b0;
    case (cls)
      CLS_DP: begin
        use_rn = !is_move_op(opc);
        use_rm = !i_bit;
      end
      CLS_MEM: begin
        use_rn = 1'b1;
        // Transfers invert the I-bit sense: I=1 means register offset.
        use_rm = i_bit;
        // Stores read rd as the data to write.
        use_rd = !l_bit;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    match  = (use_rn && (rn == ex_rd)) ||
             (use_rm && (rm == ex_rd)) ||
             (use_rd && (rd == ex_rd));
    // A load into PC redirects the pipeline, so it is never forwarded from.
    hazard = vld && ex_vld && ex_mem_read && (ex_rd != REG_PC) && match;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage of the 5-stage ARM pipeline.
// Splits the fetched instruction into register addresses, immediates and
// control flags and registers them into the ID/EX register (1-cycle latency).
// A load-use dependency against the ID/EX entry inserts a bubble and holds
// fetch through stall_o.
//   clk_i, reset_i (sync, active-low)
//   valid_i, inst_i, pc_i     : fetch output
//   stall_i                   : hold every ID/EX register
//   flush_i                   : kill the entry being written
//   stall_o                   : combinational load-use stall to fetch
//   remaining *_o             : registered ID/EX fields
module decode_stage
  import arm_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [3:0]      cond_o,
  output logic [PC_W-1:0] pc_plus8_o,
  output logic [3:0]      rn_addr_o,
  output logic [3:0]      rd_addr_o,
  output logic [3:0]      rm_addr_o,
  output logic [3:0]      alu_op_o,
  output logic            imm_sel_o,
  output logic [11:0]     imm12_o,
  output logic            set_flags_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            up_o,
  output logic            pre_o,
  output logic            branch_o,
  output logic            link_o,
  output logic [23:0]     branch_offset_o,
  output logic            writes_pc_o
);

  logic [1:0]      cls;
  logic [3:0]      opc;
  id_ex_t          dec_p0;
  id_ex_t          ex_p1;
  logic [PC_W-1:0] pc_plus8_p1;
  logic            hazard;
  logic            kill;

  assign cls = inst_i[27:26];
  assign opc = inst_i[24:21];

  // ---- p0: combinational decode of the fetch instruction ----
  always_comb begin
    dec_p0           = '0;
    dec_p0.vld       = valid_i;
    dec_p0.cond      = inst_i[31:28];
    dec_p0.rn        = inst_i[19:16];
    dec_p0.rd        = inst_i[15:12];
    dec_p0.rm        = inst_i[3:0];
    dec_p0.imm12     = inst_i[11:0];
    dec_p0.offset    = inst_i[23:0];
    case (cls)
      CLS_DP: begin
        dec_p0.alu_op    = opc;
        dec_p0.imm_sel   = inst_i[25];
        dec_p0.set_flags = inst_i[20];
        dec_p0.reg_write = !is_compare_op(opc);
      end
      CLS_MEM: begin
        dec_p0.alu_op    = OP_ADD;
        dec_p0.imm_sel   = !inst_i[25];
        dec_p0.mem_read  = inst_i[20];
        dec_p0.mem_write = !inst_i[20];
        dec_p0.reg_write = inst_i[20];
        dec_p0.up        = inst_i[23];
        dec_p0.pre       = inst_i[24];
      end
      CLS_BR: begin
        dec_p0.branch    = 1'b1;
        dec_p0.link      = inst_i[24];
        if (inst_i[24]) begin
          dec_p0.reg_write = 1'b1;
          dec_p0.rd        = REG_LR;
        end
      end
      default: begin
        // Undefined class: fields captured, entry marked dead.
        dec_p0.vld = 1'b0;
      end
    endcase
    dec_p0.writes_pc = dec_p0.reg_write && (dec_p0.rd == REG_PC) && !dec_p0.link;
    if (!valid_i) begin
      dec_p0.set_flags = 1'b0;
      dec_p0.reg_write = 1'b0;
      dec_p0.mem_read  = 1'b0;
      dec_p0.mem_write = 1'b0;
      dec_p0.branch    = 1'b0;
      dec_p0.link      = 1'b0;
      dec_p0.writes_pc = 1'b0;
    end
  end

  hazard_detect u_hazard (
    .vld         (valid_i),
    .cls         (cls),
    .opc         (opc),
    .i_bit       (inst_i[25]),
    .l_bit       (inst_i[20]),
    .rn          (inst_i[19:16]),
    .rd          (inst_i[15:12]),
    .rm          (inst_i[3:0]),
    .ex_vld      (ex_p1.vld),
    .ex_mem_read (ex_p1.mem_read),
    .ex_rd       (ex_p1.rd),
    .hazard      (hazard)
  );

  assign stall_o = hazard && !flush_i && reset_i;

  // Flush outranks stall_i; a hazard bubble only applies when not held.
  assign kill = flush_i || (!stall_i && hazard);

  // ---- p1: ID/EX register ----
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ex_p1       <= '0;
      pc_plus8_p1 <= '0;
    end else if (kill) begin
      ex_p1.vld       <= 1'b0;
      ex_p1.set_flags <= 1'b0;
      ex_p1.reg_write <= 1'b0;
      ex_p1.mem_read  <= 1'b0;
      ex_p1.mem_write <= 1'b0;
      ex_p1.branch    <= 1'b0;
      ex_p1.link      <= 1'b0;
      ex_p1.writes_pc <= 1'b0;
    end else if (!stall_i) begin
      ex_p1       <= dec_p0;
      pc_plus8_p1 <= pc_i + PC_W'(8);
    end
  end

  assign valid_o         = ex_p1.vld;
  assign cond_o          = ex_p1.cond;
  assign pc_plus8_o      = pc_plus8_p1;
  assign rn_addr_o       = ex_p1.rn;
  assign rd_addr_o       = ex_p1.rd;
  assign rm_addr_o       = ex_p1.rm;
  assign alu_op_o        = ex_p1.alu_op;
  assign imm_sel_o       = ex_p1.imm_sel;
  assign imm12_o         = ex_p1.imm12;
  assign set_flags_o     = ex_p1.set_flags;
  assign reg_write_o     = ex_p1.reg_write;
  assign mem_read_o      = ex_p1.mem_read;
  assign mem_write_o     = ex_p1.mem_write;
  assign up_o            = ex_p1.up;
  assign pre_o           = ex_p1.pre;
  assign branch_o        = ex_p1.branch;
  assign link_o          = ex_p1.link;
  assign branch_offset_o = ex_p1.offset;
  assign writes_pc_o     = ex_p1.writes_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: per-feature tasks with inline checks
// plus a scoreboard fed by a reference model at stimulus time.
module tb_decode_stage;

  localparam int PC_W = 32;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b0;
  logic            valid_i = 1'b0;
  logic [31:0]     inst_i = '0;
  logic [PC_W-1:0] pc_i = '0;
  logic            stall_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            stall_o, valid_o, imm_sel_o, set_flags_o, reg_write_o;
  logic            mem_read_o, mem_write_o, up_o, pre_o, branch_o, link_o, writes_pc_o;
  logic [3:0]      cond_o, rn_addr_o, rd_addr_o, rm_addr_o, alu_op_o;
  logic [PC_W-1:0] pc_plus8_o;
  logic [11:0]     imm12_o;
  logic [23:0]     branch_offset_o;

  decode_stage #(.PC_W(PC_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .inst_i(inst_i),
    .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .valid_o(valid_o), .cond_o(cond_o), .pc_plus8_o(pc_plus8_o),
    .rn_addr_o(rn_addr_o), .rd_addr_o(rd_addr_o), .rm_addr_o(rm_addr_o),
    .alu_op_o(alu_op_o), .imm_sel_o(imm_sel_o), .imm12_o(imm12_o),
    .set_flags_o(set_flags_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .up_o(up_o),
    .pre_o(pre_o), .branch_o(branch_o), .link_o(link_o),
    .branch_offset_o(branch_offset_o), .writes_pc_o(writes_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cond;
    logic [31:0] pc8;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  alu;
    logic        imm_sel;
    logic [11:0] imm12;
    logic        sf;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        up;
    logic        pre;
    logic        br;
    logic        lk;
    logic [23:0] off;
    logic        wpc;
  } obs_t;

  typedef struct {
    obs_t v;
    bit   full;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  obs_t m = '0;
  bit   m_known = 1'b1;
  exp_t oq[$];
  bit   sq[$];

  // ---------------- reference model ----------------
  function automatic bit model_hazard(input obs_t s, input logic vld, input logic [31:0] ins);
    bit src_n, src_m, src_d;
    src_n = 0; src_m = 0; src_d = 0;
    if (ins[27:26] == 2'b00) begin
      src_n = (ins[24:21] != 4'hD) && (ins[24:21] != 4'hF);
      src_m = (ins[25] == 1'b0);
    end else if (ins[27:26] == 2'b01) begin
      src_n = 1;
      src_m = (ins[25] == 1'b1);
      src_d = (ins[20] == 1'b0);
    end
    return vld && s.valid && s.mr && (s.rd != 4'd15) &&
           ((src_n && ins[19:16] == s.rd) || (src_m && ins[3:0] == s.rd) ||
            (src_d && ins[15:12] == s.rd));
  endfunction

  function automatic obs_t clear_ctl(input obs_t s);
    obs_t o;
    o = s;
    o.valid = 0; o.sf = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.br = 0; o.lk = 0; o.wpc = 0;
    return o;
  endfunction

  function automatic obs_t model_decode(input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    obs_t o;
    o = '0;
    o.cond = ins[31:28]; o.pc8 = pc + 32'd8;
    o.rn = ins[19:16]; o.rd = ins[15:12]; o.rm = ins[3:0];
    o.imm12 = ins[11:0]; o.off = ins[23:0];
    case (ins[27:26])
      2'b00: begin
        o.valid = vld; o.alu = ins[24:21]; o.imm_sel = ins[25]; o.sf = ins[20];
        o.rw = (ins[24:21] < 4'h8) || (ins[24:21] > 4'hB);
      end
      2'b01: begin
        o.valid = vld; o.alu = 4'b0100; o.imm_sel = ~ins[25];
        o.mr = ins[20]; o.mw = ~ins[20]; o.rw = ins[20]; o.up = ins[23]; o.pre = ins[24];
      end
      2'b10: begin
        o.valid = vld; o.br = 1; o.lk = ins[24];
        if (ins[24]) begin o.rw = 1; o.rd = 4'd14; end
      end
      default: o.valid = 0;
    endcase
    o.wpc = o.rw && (o.rd == 4'd15) && !o.lk;
    if (!vld) o = clear_ctl(o);
    return o;
  endfunction

  // Drive one cycle of stimulus and record what the DUT must show.
  task automatic drive(input bit rst_n, input bit vld, input logic [31:0] ins,
                       input logic [31:0] pc, input bit stl, input bit fl);
    bit   hz;
    exp_t e;
    reset_i = rst_n; valid_i = vld; inst_i = ins; pc_i = pc; stall_i = stl; flush_i = fl;
    hz = model_hazard(m, vld, ins);
    sq.push_back(hz && !fl && rst_n);
    if (!rst_n) begin
      m = '0; m_known = 1;
    end else if (fl) begin
      m = clear_ctl(m); m_known = 0;
    end else if (stl) begin
    end else if (hz) begin
      m = clear_ctl(m); m_known = 0;
    end else begin
      m = model_decode(vld, ins, pc); m_known = 1;
    end
    e.v = m; e.full = m_known;
    oq.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk_i);
    @(posedge clk_i);
    #2;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk_i) begin
    if (sq.size() > 0) begin
      bit es;
      es = sq.pop_front();
      checks++;
      if (stall_o !== es) begin
        errors++;
        $display("FAIL sb_stall t=%0t got=%b exp=%b", $time, stall_o, es);
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (oq.size() > 0) begin
      exp_t e;
      obs_t a;
      bit   bad;
      e = oq.pop_front();
      a = {valid_o, cond_o, pc_plus8_o, rn_addr_o, rd_addr_o, rm_addr_o, alu_op_o,
           imm_sel_o, imm12_o, set_flags_o, reg_write_o, mem_read_o, mem_write_o,
           up_o, pre_o, branch_o, link_o, branch_offset_o, writes_pc_o};
      checks++;
      if (e.full) bad = (a !== e.v);
      else bad = ({a.valid, a.sf, a.rw, a.mr, a.mw, a.br, a.lk, a.wpc} !==
                  {e.v.valid, e.v.sf, e.v.rw, e.v.mr, e.v.mw, e.v.br, e.v.lk, e.v.wpc});
      if (bad) begin
        errors++;
        $display("FAIL sb_outputs t=%0t got=%h exp=%h full=%0d", $time, a, e.v, e.full);
      end
    end
  end

  // ---------------- feature tasks ----------------
  task automatic test_reset();
    drive(0, 1, 32'hE0812003, 32'h0, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    tick();
    drive(0, 1, 32'hE0812003, 32'h0, 0, 0);
    tick();
    checks++;
    if ({valid_o, reg_write_o, rn_addr_o, rd_addr_o, alu_op_o, pc_plus8_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs got=%h exp=0", {valid_o, reg_write_o, rn_addr_o, rd_addr_o, alu_op_o, pc_plus8_o});
    end
  endtask

  task automatic test_dp();
    drive(1, 1, 32'hE0812003, 32'h100, 0, 0);
    tick();
    checks++;
    if ({valid_o, alu_op_o, rn_addr_o, rd_addr_o, rm_addr_o, imm_sel_o, reg_write_o} !==
        {1'b1, 4'h4, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dp_add got=%h exp=%h", {valid_o, alu_op_o, rn_addr_o, rd_addr_o, rm_addr_o, imm_sel_o, reg_write_o},
               {1'b1, 4'h4, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1});
    end
    checks++;
    if (pc_plus8_o !== 32'h108) begin errors++; $display("FAIL dp_pc8 got=%h exp=108", pc_plus8_o); end
    // ADDS r1,r2,#5
    drive(1, 1, 32'hE2921005, 32'h104, 0, 0);
    tick();
    checks++;
    if ({imm_sel_o, set_flags_o, imm12_o, reg_write_o} !== {1'b1, 1'b1, 12'h005, 1'b1}) begin
      errors++; $display("FAIL dp_imm got=%h exp=%h", {imm_sel_o, set_flags_o, imm12_o, reg_write_o}, {1'b1, 1'b1, 12'h005, 1'b1});
    end
    // CMP r1,r2
    drive(1, 1, 32'hE1510002, 32'h108, 0, 0);
    tick();
    checks++;
    if ({reg_write_o, set_flags_o, alu_op_o} !== {1'b0, 1'b1, 4'hA}) begin
      errors++; $display("FAIL dp_cmp got=%h exp=%h", {reg_write_o, set_flags_o, alu_op_o}, {1'b0, 1'b1, 4'hA});
    end
  endtask

  // LDR r4 then a dependent instruction: one stall, bubble, then capture.
  task automatic load_use_pair(input logic [31:0] dep, input string nm);
    drive(1, 1, 32'hE5954000, 32'h200, 0, 0);
    tick();
    drive(1, 1, dep, 32'h204, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL %s_stall got=%b exp=1", nm, stall_o); end
    tick();
    checks++;
    if ({valid_o, reg_write_o, mem_read_o} !== 3'b000) begin
      errors++; $display("FAIL %s_bubble got=%b exp=000", nm, {valid_o, reg_write_o, mem_read_o});
    end
    drive(1, 1, dep, 32'h204, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL %s_release got=%b exp=0", nm, stall_o); end
    tick();
    checks++;
    if ({valid_o, rn_addr_o, rd_addr_o} !== {1'b1, dep[19:16], dep[15:12]}) begin
      errors++; $display("FAIL %s_capture got=%h exp=%h", nm, {valid_o, rn_addr_o, rd_addr_o}, {1'b1, dep[19:16], dep[15:12]});
    end
  endtask

  task automatic test_load_use();
    drive(1, 1, 32'hE5954000, 32'h1F0, 0, 0);
    tick();
    checks++;
    if ({mem_read_o, mem_write_o, reg_write_o, imm_sel_o, alu_op_o, up_o, pre_o, rd_addr_o} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4}) begin
      errors++; $display("FAIL ldr_decode got=%h", {mem_read_o, mem_write_o, reg_write_o, imm_sel_o, alu_op_o, up_o, pre_o, rd_addr_o});
    end
    load_use_pair(32'hE0846007, "lu_rn");
    load_use_pair(32'hE5864000, "lu_str_rd");
    checks++;
    if ({mem_write_o, reg_write_o} !== 2'b10) begin
      errors++; $display("FAIL str_decode got=%b exp=10", {mem_write_o, reg_write_o});
    end
    load_use_pair(32'hE7910004, "lu_rm");
    // Non-dependent ADD after a load.
    drive(1, 1, 32'hE5954000, 32'h300, 0, 0);
    tick();
    drive(1, 1, 32'hE0886007, 32'h304, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_nodep got=%b exp=0", stall_o); end
    tick();
    checks++;
    if ({valid_o, rn_addr_o} !== {1'b1, 4'h8}) begin
      errors++; $display("FAIL lu_nodep_cap got=%h exp=18", {valid_o, rn_addr_o});
    end
  endtask

  task automatic test_branch();
    drive(1, 1, 32'hEB00000A, 32'h400, 0, 0);
    tick();
    checks++;
    if ({branch_o, link_o, rd_addr_o, reg_write_o, writes_pc_o, branch_offset_o} !==
        {1'b1, 1'b1, 4'd14, 1'b1, 1'b0, 24'h00000A}) begin
      errors++; $display("FAIL bl got=%h exp=%h", {branch_o, link_o, rd_addr_o, reg_write_o, writes_pc_o, branch_offset_o},
                         {1'b1, 1'b1, 4'd14, 1'b1, 1'b0, 24'h00000A});
    end
    drive(1, 1, 32'hEA000004, 32'h404, 0, 0);
    tick();
    checks++;
    if ({branch_o, link_o, reg_write_o} !== 3'b100) begin
      errors++; $display("FAIL b got=%b exp=100", {branch_o, link_o, reg_write_o});
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 32'hE0812003, 32'h500, 0, 1);
    tick();
    checks++;
    if ({valid_o, reg_write_o} !== 2'b00) begin errors++; $display("FAIL flush got=%b exp=00", {valid_o, reg_write_o}); end
    drive(1, 1, 32'hE5954000, 32'h504, 0, 0);
    tick();
    drive(1, 1, 32'hE0846007, 32'h508, 0, 1);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_hazard got=%b exp=0", stall_o); end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_hazard_vld got=%b exp=0", valid_o); end
  endtask

  task automatic test_stall();
    logic [31:0] other[3];
    other[0] = 32'hE5954000; other[1] = 32'hEB00000A; other[2] = 32'hE2921005;
    drive(1, 1, 32'hE0812003, 32'h600, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, other[i], 32'h700 + 32'(i * 4), 1, 0);
      tick();
      checks++;
      if ({valid_o, rn_addr_o, rd_addr_o, rm_addr_o, alu_op_o, reg_write_o, mem_read_o, pc_plus8_o} !==
          {1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0, 32'h608}) begin
        errors++; $display("FAIL stall_hold%0d got=%h", i, {valid_o, rn_addr_o, rd_addr_o, rm_addr_o, alu_op_o, reg_write_o, mem_read_o, pc_plus8_o});
      end
    end
    // Downstream stall coinciding with a hazard: registers hold, stall_o still up.
    drive(1, 1, 32'hE5954000, 32'h800, 0, 0);
    tick();
    drive(1, 1, 32'hE0846007, 32'h804, 1, 0);
    #1; checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_hz got=%b exp=1", stall_o); end
    tick();
    checks++;
    if ({valid_o, mem_read_o, rd_addr_o} !== {1'b1, 1'b1, 4'h4}) begin
      errors++; $display("FAIL stall_hz_hold got=%h exp=%h", {valid_o, mem_read_o, rd_addr_o}, {1'b1, 1'b1, 4'h4});
    end
    load_use_pair(32'hE0846007, "stall_after");
  endtask

  task automatic test_writes_pc();
    drive(1, 1, 32'hE1A0F00E, 32'h900, 0, 0);
    tick();
    checks++;
    if ({writes_pc_o, rd_addr_o, reg_write_o, rm_addr_o} !== {1'b1, 4'd15, 1'b1, 4'd14}) begin
      errors++; $display("FAIL mov_pc got=%h", {writes_pc_o, rd_addr_o, reg_write_o, rm_addr_o});
    end
    drive(1, 1, 32'hE595F000, 32'h904, 0, 0);
    tick();
    drive(1, 1, 32'hE08F0001, 32'h908, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL ldr_pc_nohaz got=%b exp=0", stall_o); end
    tick();
    drive(1, 1, 32'hE595F000, 32'h90C, 0, 0);
    tick();
    drive(1, 1, 32'hE1A0F00E, 32'h910, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL ldr_pc_mov got=%b exp=0", stall_o); end
    tick();
  endtask

  task automatic test_misc();
    drive(1, 1, 32'hE0812003, 32'hFFFFFFFC, 0, 0);
    tick();
    checks++;
    if (pc_plus8_o !== 32'h4) begin errors++; $display("FAIL pc_wrap got=%h exp=4", pc_plus8_o); end
    drive(1, 1, 32'hEC000000, 32'hA00, 0, 0);
    tick();
    checks++;
    if ({valid_o, reg_write_o, branch_o} !== 3'b000) begin
      errors++; $display("FAIL undef got=%b exp=000", {valid_o, reg_write_o, branch_o});
    end
    drive(1, 0, 32'hE0812003, 32'hA04, 0, 0);
    tick();
    checks++;
    if ({valid_o, reg_write_o} !== 2'b00) begin errors++; $display("FAIL invalid got=%b exp=00", {valid_o, reg_write_o}); end
    // Reset while a load-use stall is pending.
    drive(1, 1, 32'hE5954000, 32'hA08, 0, 0);
    tick();
    drive(0, 1, 32'hE0846007, 32'hA0C, 0, 0);
    #1; checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    tick();
    drive(1, 1, 32'hE0846007, 32'hA0C, 0, 0);
    #1; checks++;
    if ({valid_o, stall_o} !== 2'b00) begin errors++; $display("FAIL rst_after got=%b exp=00", {valid_o, stall_o}); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool[8];
    logic [31:0] ins;
    logic [3:0]  regs[4];
    pool[0] = 32'hE0812003; pool[1] = 32'hE5954000; pool[2] = 32'hE5864000;
    pool[3] = 32'hE7910004; pool[4] = 32'hE1A0F00E; pool[5] = 32'hEB00000A;
    pool[6] = 32'hE2921005; pool[7] = 32'hEC000000;
    regs[0] = 4'd4; regs[1] = 4'd5; regs[2] = 4'd15; regs[3] = 4'd1;
    for (int i = 0; i < 300; i++) begin
      ins = pool[$urandom_range(0, 7)];
      ins[19:16] = regs[$urandom_range(0, 3)];
      ins[15:12] = regs[$urandom_range(0, 3)];
      ins[3:0]   = regs[$urandom_range(0, 3)];
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, ins, $urandom,
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
  endtask

  initial begin
    @(posedge clk_i);
    #2;
    test_reset();
    test_dp();
    test_load_use();
    test_branch();
    test_flush();
    test_stall();
    test_writes_pc();
    test_misc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
